// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for dmem_access_ctrl: two requester ports (MEM stage, loader),
// pipeline/status outputs and the data RAM pins.
//   slave  : the controller side (drives acks, read data, stall/busy, RAM pins)
//   master : the environment side (requesters plus the RAM's DataOut)
interface dmem_access_ctrl_if;
  // Port 0: pipeline MEM stage
  logic        p0_req;
  logic        p0_rw;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;
  // Port 1: program/data loader
  logic        p1_req;
  logic        p1_rw;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;
  // Pipeline and status
  logic        mem_stall;
  logic        busy;
  // RAM side
  logic        ram_enable;
  logic        ram_rw;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  p0_req, p0_rw, p0_size, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_rw, p1_size, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_stall, busy,
    output ram_enable, ram_rw, ram_size, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output p0_req, p0_rw, p0_size, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_rw, p1_size, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_stall, busy,
    input  ram_enable, ram_rw, ram_size, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer and round-robin two-port arbiter for data_ram256x8.
// Converts each req/ack transaction into the RAM's level-sensitive
// Enable/ReadWrite sequence (SETUP with enable low, STROBE with enable high,
// DONE with ack) and returns zero-extended read data.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - dmem_access_ctrl_if.slave: p0_*/p1_* request ports, mem_stall, busy,
//           ram_* pins towards the RAM
// Parameters:
//   ADDR_LIMIT - RAM size in bytes; a request is in range if addr + bytes <= ADDR_LIMIT
// Build option:
//   DMEM_CTRL_ALIGN_CHECK_EN - when defined, misaligned halfword/word requests
//   take the error path instead of reaching the RAM.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input logic               clk,
  input logic               reset,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = port 0, 1 = port 1
  logic        grant_q, grant_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Arbitration result and the selected port's request fields
  logic        sel;
  logic        req_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  nbytes;
  logic [32:0] req_end;
  logic        misaligned;
  logic        illegal;

  always_comb begin
    // On a tie the port that did not win last time is served
    if (bus.p0_req && bus.p1_req) begin
      sel = ~last_grant_q;
    end else begin
      sel = bus.p1_req;
    end
    req_rw    = sel ? bus.p1_rw    : bus.p0_rw;
    req_size  = sel ? bus.p1_size  : bus.p0_size;
    req_addr  = sel ? bus.p1_addr  : bus.p0_addr;
    req_wdata = sel ? bus.p1_wdata : bus.p0_wdata;

    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    req_end = {1'b0, req_addr} + 33'(nbytes);

`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif

    illegal = (req_size == 2'b11) || (req_end > 33'(ADDR_LIMIT)) || misaligned;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rw_d         = rw_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      StIdle: begin
        if (bus.p0_req || bus.p1_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          rw_d         = req_rw;
          size_d       = req_size;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          rdata_d      = '0;
          err_d        = illegal;
          // Illegal requests skip the RAM entirely
          state_d      = illegal ? StDone : StSetup;
        end
      end
      StSetup: state_d = StStrobe;
      StStrobe: begin
        state_d = StDone;
        if (!rw_q) begin
          case (size_q)
            2'b00:   rdata_d = {24'b0, bus.ram_rdata[7:0]};
            2'b01:   rdata_d = {16'b0, bus.ram_rdata[15:0]};
            default: rdata_d = bus.ram_rdata;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  logic drive_pins;
  logic done0;
  logic done1;

  always_comb begin
    drive_pins    = (state_q == StSetup) || (state_q == StStrobe);
    done0         = (state_q == StDone) && !grant_q;
    done1         = (state_q == StDone) && grant_q;

    bus.ram_enable = (state_q == StStrobe);
    bus.ram_rw     = drive_pins & rw_q;
    bus.ram_size   = drive_pins ? size_q  : 2'b00;
    bus.ram_addr   = drive_pins ? addr_q  : '0;
    bus.ram_wdata  = drive_pins ? wdata_q : '0;

    bus.p0_ack     = done0;
    bus.p0_err     = done0 & err_q;
    bus.p0_rdata   = done0 ? rdata_q : '0;
    bus.p1_ack     = done1;
    bus.p1_err     = done1 & err_q;
    bus.p1_rdata   = done1 ? rdata_q : '0;

    bus.mem_stall  = bus.p0_req & ~done0;
    bus.busy       = (state_q != StIdle);
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer and two-port arbiter for `data_ram256x8`. It shares the data RAM between the pipeline MEM stage (port 0) and the program/data loader (port 1). It converts each request/ack transaction into the RAM's level-sensitive Enable/ReadWrite strobe sequence and returns aligned, zero-extended read data. It also drives `mem_stall` so the pipeline holds its MEM stage until its access completes.

## Interface
Parameters:
- `ADDR_LIMIT`, 256: RAM size in bytes. A request is in range when `addr + bytes(size) <= ADDR_LIMIT`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: rising-edge clock.
  - `reset` in 1: synchronous, active-high reset.
- Port 0 (MEM stage):
  - `p0_req` in 1: request.
  - `p0_rw` in 1: 1 = write, 0 = read.
  - `p0_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
  - `p0_addr` in 32: byte address.
  - `p0_wdata` in 32: write data, right-justified.
  - `p0_ack` out 1: one-cycle completion pulse.
  - `p0_err` out 1: error flag, valid with `p0_ack`.
  - `p0_rdata` out 32: read data, valid with `p0_ack`.
- Port 1 (loader): `p1_req`, `p1_rw`, `p1_size`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_err`, `p1_rdata`, identical to port 0.
- Pipeline and status:
  - `mem_stall` out 1: equals `p0_req & ~p0_ack`.
  - `busy` out 1: high whenever state ≠ IDLE.
- RAM side:
  - `ram_enable` out 1: to RAM Enable.
  - `ram_rw` out 1: to RAM ReadWrite.
  - `ram_size` out 2: to RAM Size.
  - `ram_addr` out 32: to RAM Address.
  - `ram_wdata` out 32: to RAM DataIn.
  - `ram_rdata` in 32: from RAM DataOut.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, DONE.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - Otherwise grant one port and latch its rw, size, addr and wdata.
  - If the latched request is legal, go to SETUP. If it is illegal, go straight to DONE with the error flag set.
- **Arbitration:** round-robin on a `last_grant` register.
  - If both ports request, the port not in `last_grant` wins.
  - `last_grant` updates on every grant, including error grants.
- **Legality:** a request is illegal in either case below, regardless of configuration:
  - `size == 11`.
  - The request is out of `ADDR_LIMIT` range.
- **SETUP:** drive the latched rw, size, addr and wdata onto the RAM pins with `ram_enable = 0`.
- **STROBE:** hold the RAM pins and set `ram_enable = 1`. This rising edge triggers the RAM.
- **DONE:**
  - Set `ram_enable = 0`.
  - Pulse the granted port's ack for one cycle, then return to IDLE.
  - Read data is captured from `ram_rdata` on the STROBE→DONE clock edge:
    - byte → `{24'b0, ram_rdata[7:0]}`
    - halfword → `{16'b0, ram_rdata[15:0]}`
    - word → unchanged
  - Writes return `rdata = 0`.
- **Error transaction:** `err = 1`, `rdata = 0`, and `ram_enable` is never asserted.
- **Ungranted port:** its ack, err and rdata are held at 0.
- **Requester rules:**
  - Hold req and all fields stable until ack.
  - If req is still high in the cycle after ack, that is a new transaction.
  - Fields that change while req is high before grant are sampled at the grant edge only.

## Timing
- **Legal access:** req first seen high in IDLE at edge n; the FSM is in SETUP after n, STROBE after n+1 and DONE after n+2. `ack` is high for the cycle after edge n+2. Latency is 3 cycles.
- **Illegal access:** `ack` and `err` are high in the cycle after edge n. Latency is 1 cycle.
- **Back-to-back:** minimum spacing between grants is 4 cycles. Each IDLE cycle in between arbitrates.
- **Reset values:**
  - All outputs 0; state IDLE.
  - `last_grant` = port 1, so port 0 wins the first tie.
- **Reset mid-transaction:**
  - Next edge forces IDLE and `ram_enable = 0`; no ack is issued.
  - A write already strobed stays committed.
- **`mem_stall`:** combinational and also high during port 1 transactions, but only while `p0_req` is high.

## Configuration
- **`DMEM_CTRL_ALIGN_CHECK_EN` defined:** misaligned requests are illegal and take the 1-cycle error path with no RAM access.
  - Halfword is misaligned when `addr[0] != 0`.
  - Word is misaligned when `addr[1:0] != 0`.
- **Undefined:** alignment is not checked. Misaligned requests that are in range go to the RAM unmodified. Range and size checks still apply.

## Test plan
- **Word write/read:** port 0 writes word 0xDEADBEEF at 0x10, then reads 0x10.
  - `ram_enable` is high exactly one cycle per access.
  - `p0_ack` comes 3 cycles after req.
  - `p0_rdata` = 0xDEADBEEF, `p0_err` = 0.
- **Zero-extension:** preload 0xA5 at 0x21, then port 1 reads a byte at 0x21 → `p1_rdata` = 0x000000A5. A halfword read at 0x20 returns 0x0000xxA5-consistent bytes.
- **Round-robin:** both ports request continuously from reset. Grants go P0, P1, P0, P1. `mem_stall` is high until each `p0_ack`, and each ack is a single cycle.
- **Illegal requests:**
  - `size = 11` → ack+err 1 cycle after req, `ram_enable` never rises.
  - Word at 0xFE → same error behaviour (out of range).
- **Alignment (`DMEM_CTRL_ALIGN_CHECK_EN` defined):** word read at 0x13 → `err = 1`, no strobe.
  - Without the macro, the same request gets a strobe and `err = 0`.
- **Reset in STROBE:** assert `reset` during STROBE. Next cycle: state IDLE, `ram_enable = 0`, no ack. A following request completes normally with port 0 priority.
